// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared fetch-stage types and helpers
package cpu_types_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_BR  = 2'd1,
    PC_JMP = 2'd2
  } pcsrc_t;

  // Jump wins over a taken branch resolved in the same cycle
  function automatic pcsrc_t redirect_src(input logic jump);
    return jump ? PC_JMP : PC_BR;
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// rtl/fetch_watchdog.sv - saturating counter of consecutive unanswered fetch cycles
module fetch_watchdog #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic CLK,
  input  logic nRST,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CW = ($clog2(WAIT_LIMIT + 1) > 8) ? $clog2(WAIT_LIMIT + 1) : 8;
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

  logic [CW-1:0] cnt;

  // Count unanswered cycles, saturating at the limit; any answer restarts the count
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIMIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Fires during the cycle that brings the count to the limit so the sticky
  // error is visible right after that cycle's edge
  assign expired = en && (cnt >= (LIMIT - CW'(1)));

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencing: PC enable, redirect, stall and halt control
module fetch_ctrl
  import cpu_types_pkg::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        halt,
  output logic        iREN,
  output logic        pcEN,
  output logic [1:0]  pc_src,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        redirect_ack,
  output logic        halted,
  output logic [31:0] fetch_cnt,
  output logic        fetch_err
);

  fetch_state_t state_q, state_d;
  logic         pend_valid_q, pend_valid_d;
  pcsrc_t       pend_src_q, pend_src_d;
  logic         err_q;
  logic         redirect;
  logic         wd_en, wd_clr, wd_expired;

  assign redirect = jump | branch_taken;

  // State, pending redirect, fetch counter and sticky error registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      pend_valid_q <= 1'b0;
      pend_src_q   <= PC_SEQ;
      fetch_cnt    <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_src_q   <= pend_src_d;
      if (pcEN) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (wd_expired) begin
        err_q <= 1'b1;
      end
    end
  end

  // Next state and Mealy outputs; priority is halt, redirect, stall, sequential
  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_src_d   = pend_src_q;
    iREN         = 1'b0;
    pcEN         = 1'b0;
    pc_src       = PC_SEQ;
    ifid_en      = 1'b0;
    ifid_flush   = 1'b0;
    redirect_ack = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = halt ? HALT : FETCH;
      end
      FETCH: begin
        iREN = 1'b1;
        if (!ihit) begin
          // Memory not answered yet: remember the redirect, defer any halt
          if (redirect) begin
            pend_valid_d = 1'b1;
            pend_src_d   = redirect_src(jump);
          end
        end else if (halt) begin
          ifid_en      = 1'b1;
          pend_valid_d = 1'b0;
          state_d      = HALT;
        end else if (redirect || pend_valid_q) begin
          // A fresh redirect this cycle supersedes the remembered one
          pcEN         = 1'b1;
          pc_src       = redirect ? redirect_src(jump) : pend_src_q;
          ifid_flush   = 1'b1;
          redirect_ack = 1'b1;
          pend_valid_d = 1'b0;
        end else if (stall) begin
          state_d = HOLD;
        end else begin
          pcEN    = 1'b1;
          ifid_en = 1'b1;
        end
      end
      HOLD: begin
        if (halt) begin
          state_d = HALT;
        end else if (redirect) begin
          pcEN         = 1'b1;
          pc_src       = redirect_src(jump);
          ifid_flush   = 1'b1;
          redirect_ack = 1'b1;
          state_d      = FETCH;
        end else if (!stall) begin
          pcEN    = 1'b1;
          ifid_en = 1'b1;
          state_d = FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign halted    = (state_q == HALT);
  assign fetch_err = err_q;
  assign wd_en     = (state_q == FETCH) && !ihit;
  assign wd_clr    = ihit;

  fetch_watchdog #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_watchdog (
    .CLK    (CLK),
    .nRST   (nRST),
    .en     (wd_en),
    .clr    (wd_clr),
    .expired(wd_expired)
  );

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter: WAIT_LIMIT, 255, consecutive unanswered FETCH cycles before fetch_err sets.
REQ-002 SHALL have port: CLK  in  1  system clock, rising edge.
REQ-003 SHALL have port: nRST  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: ihit  in  1  instruction memory returned data this cycle.
REQ-005 SHALL have port: stall  in  1  downstream hazard stall request.
REQ-006 SHALL have port: branch_taken  in  1  branch resolved taken this cycle.
REQ-007 SHALL have port: jump  in  1  jump resolved this cycle.
REQ-008 SHALL have port: halt  in  1  halt instruction detected.
REQ-009 SHALL have port: iREN  out  1  instruction memory read request.
REQ-010 SHALL have port: pcEN  out  1  PC register update enable.
REQ-011 SHALL have port: pc_src  out  2  PC next-value select (0 seq, 1 branch, 2 jump).
REQ-012 SHALL have port: ifid_en  out  1  IF/ID latch enable.
REQ-013 SHALL have port: ifid_flush  out  1  IF/ID bubble insert.
REQ-014 SHALL have port: redirect_ack  out  1  one-cycle pulse when a branch/jump redirect is applied; datapath holds target operands stable until then.
REQ-015 SHALL have ports: halted out 1 (sticky halt status); fetch_cnt out 32 (PC updates since reset); fetch_err out 1 (sticky memory timeout).

Function
REQ-016 States SHALL be IDLE, FETCH, HOLD, HALT; outputs Mealy from state, pend register and inputs.
REQ-017 Priority SHALL be halt > redirect > stall > sequential; jump over branch_taken when both asserted.
REQ-018 IDLE: all outputs 0; unconditional transition to FETCH next cycle.
REQ-019 FETCH: iREN=1; without ihit, pcEN=0, ifid_en=0, ifid_flush=0.
REQ-020 FETCH, ihit, no redirect, no pend, !stall: pcEN=1, pc_src=0, ifid_en=1; stay FETCH.
REQ-021 FETCH, redirect asserted with ihit: pcEN=1, pc_src=redirect source, ifid_flush=1, ifid_en=0, redirect_ack=1; stay FETCH.
REQ-022 FETCH, redirect asserted without ihit: latch source into pend (jump overrides branch); pcEN=0; no ack.
REQ-023 FETCH, ihit with pend valid: apply as REQ-021 using pend source; clear pend same edge; a new redirect that cycle overrides pend.
REQ-024 FETCH, ihit, stall, no redirect/pend: pcEN=0, ifid_en=0; go HOLD.
REQ-025 HOLD: iREN=0; on !stall pcEN=1, pc_src=0, ifid_en=1, go FETCH; on redirect apply as REQ-021 without ihit, go FETCH.
REQ-026 halt in FETCH without ihit SHALL defer until ihit; then pcEN=0, ifid_en=1, go HALT; halt in HOLD/IDLE goes HALT next edge.
REQ-027 HALT: iREN, pcEN, ifid_en, ifid_flush, redirect_ack = 0; halted=1; exits only by reset.
REQ-028 fetch_cnt SHALL increment by 1 on each cycle pcEN=1; wraps 0xFFFFFFFF -> 0.
REQ-029 wait counter (8-bit min, saturating) SHALL count consecutive FETCH cycles with iREN=1 and !ihit, clear on ihit; reaching WAIT_LIMIT sets fetch_err sticky; fetch operation unaffected.

Reset
REQ-030 nRST low SHALL immediately force state IDLE, pend cleared, fetch_cnt=0, wait counter=0, halted=0, fetch_err=0, all outputs 0.
REQ-031 Reset mid-redirect or mid-wait SHALL discard the pending redirect; no ack issued.

Structure
REQ-032 fetch_state_t enum and pcsrc_t (PC_SEQ=0, PC_BR=1, PC_JMP=2) SHALL reside in cpu_types_pkg.
REQ-033 Timeout counter SHALL be sub-module fetch_watchdog (inputs: count enable, clear; output: expired); remainder in fetch_ctrl.

Verification
REQ-034 Reset, then ihit=1 for 4 cycles, stall=0 -> IDLE 1 cycle, 4 pcEN pulses with pc_src=0, fetch_cnt=4.
REQ-035 jump=1 and branch_taken=1 with ihit=1 -> pc_src=2, ifid_flush=1, redirect_ack=1 same cycle.
REQ-036 branch_taken=1 with ihit=0, ihit=1 three cycles later -> no pcEN until then; then pc_src=1, flush, ack once.
REQ-037 ihit with stall=1 for 3 cycles -> HOLD, iREN=0, pcEN=0; stall drop -> pcEN=1, back FETCH.
REQ-038 halt=1 with ihit=0, ihit 2 cycles later -> HALT after ihit, halted=1, iREN=0 until nRST.
REQ-039 WAIT_LIMIT=4, ihit held 0 -> fetch_err=1 after 4th unanswered cycle, stays 1 after ihit; nRST clears it.
